// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: a 2-flop synchronizer and start-edge detector feed a
// bit-period FSM that samples mid-bit and delivers each frame with parity/framing flags.
module uart_rx_ovs #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 sync1;
    logic                 line;
    logic                 line_prev;
    logic [CNT_W-1:0]     cnt;
    logic [3:0]           idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 stop_bad;
    logic                 tick;
    logic                 done;
    logic                 start_edge;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1     <= 1'b1;
            line      <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync1     <= rxd;
            line      <= sync1;
            line_prev <= line;
        end
    end

    assign start_edge = line_prev & ~line;
    assign busy       = (state != S_IDLE);

    // The first sample lands half a bit after the edge; later ones a full bit apart.
    always_comb begin
        tick = 1'b0;
        if (state == S_START) tick = (cnt == HALF_LAST);
        else                  tick = (cnt == BIT_LAST);
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_edge) state_next = S_START;
            end
            S_START: begin
                if (tick) state_next = line ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (tick && idx == DATA_LAST) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (tick) state_next = S_STOP;
            end
            S_STOP: begin
                if (tick && idx == STOP_LAST) begin
                    state_next = S_IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            stop_bad   <= 1'b0;
            valid      <= 1'b0;
            data       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= done;

            if (state == S_IDLE || tick) cnt <= '0;
            else                         cnt <= cnt + CNT_W'(1);

            if (state_next != state) idx <= '0;
            else if (tick)           idx <= idx + 4'd1;

            if (state == S_IDLE) begin
                par_acc  <= 1'b0;
                stop_bad <= 1'b0;
            end

            if (tick) begin
                case (state)
                    S_DATA: begin
                        shreg   <= {line, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ line;
                    end
                    S_PARITY: par_acc <= par_acc ^ line;
                    S_STOP:   if (!line) stop_bad <= 1'b1;
                    default: ;
                endcase
            end

            // The final stop sample is folded in directly since stop_bad lags it by a cycle.
            if (done) begin
                data      <= shreg;
                frame_err <= stop_bad | ~line;
                if (PARITY == 1)      parity_err <= ~par_acc;
                else if (PARITY == 2) parity_err <= par_acc;
                else                  parity_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed and randomized frames into an 8N1 receiver and an 8E2 receiver, checked
// against expectations computed from the serial frame contents.
module tb_uart_rx_ovs;

    localparam int CPB0 = 16;
    localparam int CPB1 = 10;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd0 = 1'b1;
    logic       rxd1 = 1'b1;
    logic       valid0, perr0, ferr0, busy0;
    logic       valid1, perr1, ferr1, busy1;
    logic [7:0] data0, data1;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        int unsigned t;
    } rec_t;

    rec_t        q0[$];
    rec_t        q1[$];
    int unsigned starts0[$];
    int unsigned starts1[$];

    uart_rx_ovs #(.CLKS_PER_BIT(CPB0), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rstn(rstn), .rxd(rxd0), .valid(valid0), .data(data0),
        .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
    );

    uart_rx_ovs #(.CLKS_PER_BIT(CPB1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .rstn(rstn), .rxd(rxd1), .valid(valid1), .data(data1),
        .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid0) q0.push_back('{data0, perr0, ferr0, cyc});
        if (valid1) q1.push_back('{data1, perr1, ferr1, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rxd0 = v;
        else          rxd1 = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int cpb_of(input int sel);
        return (sel == 0) ? CPB0 : CPB1;
    endfunction

    // Frame bits: start, 8 data LSB first, optional parity (pbit < 0 means none), stop bits.
    task automatic send(input int sel, input logic [7:0] d, input int pbit,
                        input logic [1:0] stops, input int nstop);
        int cpb;
        cpb = cpb_of(sel);
        if (sel == 0) starts0.push_back(cyc);
        else          starts1.push_back(cyc);
        drive(sel, 1'b0);
        hold(cpb);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            hold(cpb);
        end
        if (pbit >= 0) begin
            drive(sel, pbit[0]);
            hold(cpb);
        end
        for (int s = 0; s < nstop; s++) begin
            drive(sel, stops[s]);
            hold(cpb);
        end
    endtask

    // Line fall reaches T0 after the 2-cycle synchronizer; valid follows T0 by
    // CPB/2 + (bits-1)*CPB + 1 where bits counts start, data, parity and stop.
    function automatic int unsigned latency(input int sel);
        int nbits;
        nbits = (sel == 0) ? (1 + 8 + 0 + 1) : (1 + 8 + 1 + 2);
        return 2 + cpb_of(sel) / 2 + (nbits - 1) * cpb_of(sel) + 1;
    endfunction

    task automatic expect_frame(input int sel, input string tag, input logic [7:0] d,
                                input logic pe, input logic fe);
        int   n;
        rec_t r;
        int unsigned st;
        n = 0;
        while (((sel == 0) ? q0.size() : q1.size()) == 0 && n < 4 * cpb_of(sel)) begin
            @(negedge clk);
            n++;
        end
        if (((sel == 0) ? q0.size() : q1.size()) == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (sel == 0) begin
            r  = q0.pop_front();
            st = starts0.pop_front();
        end else begin
            r  = q1.pop_front();
            st = starts1.pop_front();
        end
        check({tag, "_data"}, {24'd0, r.d}, {24'd0, d});
        check({tag, "_perr"}, {31'd0, r.pe}, {31'd0, pe});
        check({tag, "_ferr"}, {31'd0, r.fe}, {31'd0, fe});
        check({tag, "_lat"}, r.t - st, latency(sel));
    endtask

    function automatic logic even_err(input logic [7:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) == 1;
    endfunction

    initial begin
        logic [7:0] d;
        logic       p;
        logic [1:0] st;

        // Reset state
        hold(3);
        check("rst_valid0", {31'd0, valid0}, 32'd0);
        check("rst_data0",  {24'd0, data0},  32'd0);
        check("rst_busy0",  {31'd0, busy0},  32'd0);
        check("rst_perr1",  {31'd0, perr1},  32'd0);
        check("rst_ferr1",  {31'd0, ferr1},  32'd0);
        rstn = 1'b1;
        hold(5 * CPB0);
        check("idle_noframe", q0.size() + q1.size(), 32'd0);
        check("idle_busy",    {30'd0, busy0, busy1}, 32'd0);

        // Basic receive
        send(0, 8'hA5, -1, 2'b01, 1);
        expect_frame(0, "basic", 8'hA5, 1'b0, 1'b0);
        hold(CPB0);
        check("basic_single", q0.size(), 32'd0);

        // Glitch shorter than half a bit
        drive(0, 1'b0);
        hold(4);
        check("glitch_busy_up", {31'd0, busy0}, 32'd1);
        drive(0, 1'b1);
        hold(2 * CPB0);
        check("glitch_busy_down", {31'd0, busy0}, 32'd0);
        check("glitch_novalid", q0.size(), 32'd0);

        // Even parity
        send(1, 8'h3C, 1, 2'b11, 2);
        expect_frame(1, "par1", 8'h3C, 1'b1, 1'b0);
        hold(CPB1);
        send(1, 8'h3C, 0, 2'b11, 2);
        expect_frame(1, "par0", 8'h3C, 1'b0, 1'b0);
        hold(CPB1);

        // Low stop bit, then line held low
        send(0, 8'h55, -1, 2'b00, 1);
        expect_frame(0, "frm", 8'h55, 1'b0, 1'b1);
        hold(40 * CPB0);
        check("frm_quiet", q0.size(), 32'd0);
        check("frm_idle",  {31'd0, busy0}, 32'd0);
        drive(0, 1'b1);
        hold(2 * CPB0);
        send(0, 8'h12, -1, 2'b01, 1);
        expect_frame(0, "frm_next", 8'h12, 1'b0, 1'b0);
        hold(CPB0);

        // Back-to-back
        send(0, 8'h00, -1, 2'b01, 1);
        send(0, 8'hFF, -1, 2'b01, 1);
        expect_frame(0, "b2b_a", 8'h00, 1'b0, 1'b0);
        expect_frame(0, "b2b_b", 8'hFF, 1'b0, 1'b0);
        hold(CPB0);

        // Reset during data bit 3
        starts0.push_back(cyc);
        d = 8'h81;
        drive(0, 1'b0);
        hold(CPB0);
        for (int i = 0; i < 3; i++) begin
            drive(0, d[i]);
            hold(CPB0);
        end
        drive(0, d[3]);
        hold(CPB0 / 2);
        check("mid_busy_pre", {31'd0, busy0}, 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_valid", {31'd0, valid0}, 32'd0);
        check("mid_data",  {24'd0, data0},  32'd0);
        check("mid_ferr",  {31'd0, ferr0},  32'd0);
        check("mid_busy",  {31'd0, busy0},  32'd0);
        check("mid_data1", {24'd0, data1},  32'd0);
        void'(starts0.pop_back());
        drive(0, 1'b1);
        hold(3);
        rstn = 1'b1;
        hold(3 * CPB0);
        check("mid_novalid", q0.size(), 32'd0);
        send(0, 8'h7E, -1, 2'b01, 1);
        expect_frame(0, "mid_next", 8'h7E, 1'b0, 1'b0);
        hold(CPB0);

        // Randomized 8N1 frames, occasional bad stop bit
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            st = {1'b1, ($urandom_range(0, 3) != 0)};
            send(0, d, -1, st, 1);
            expect_frame(0, $sformatf("rnd0_%0d", k), d, 1'b0, ~st[0]);
            drive(0, 1'b1);
            hold(CPB0 * (1 + $urandom_range(0, 1)));
        end

        // Randomized 8E2 frames, random parity bit and stop bits
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            p  = 1'($urandom);
            st = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            send(1, d, int'(p), st, 2);
            expect_frame(1, $sformatf("rnd1_%0d", k), d, even_err(d, p), ~(st[0] & st[1]));
            drive(1, 1'b1);
            hold(CPB1 * (1 + $urandom_range(0, 1)));
        end

        check("end_q0", q0.size(), 32'd0);
        check("end_q1", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
